// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter generator for an instruction fetch stage, with a small
//   circular return-address stack (RAS) for call/return prediction.
//
//   All addresses are word-granular: bit ADDR_OFS of a byte address is bit 0
//   of the instruction index.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   rst_addr     reset vector, sampled every cycle while rst is high
//   trap         trap request             / trap_vec     trap target
//   br_taken     taken branch or jump     / br_target    branch target
//   call         call redirect            / call_target  call target
//   call_link    return address pushed on a call
//   ret          return redirect          / ret_fallback target used when the RAS is empty
//   pc_ready     fetch accepts pc_addr this cycle
//   pc_valid     pc_addr is valid
//   pc_addr      current fetch address (registered)
//   ras_count    number of valid RAS entries
//   ras_ovf      one-cycle pulse: push onto a full RAS (oldest entry lost)
//   ras_unf      one-cycle pulse: return with an empty RAS
module pc_fetch_unit #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int INSN_SIZE  = 4,
  parameter  int RAS_DEPTH  = 4,
  localparam int ADDR_OFS   = $clog2(INSN_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   rst_addr,
  input  logic                           trap,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   trap_vec,
  input  logic                           br_taken,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   br_target,
  input  logic                           call,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   call_target,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   call_link,
  input  logic                           ret,
  input  logic [ADDR_WIDTH-1:ADDR_OFS]   ret_fallback,
  input  logic                           pc_ready,
  output logic                           pc_valid,
  output logic [ADDR_WIDTH-1:ADDR_OFS]   pc_addr,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int AW = ADDR_WIDTH - ADDR_OFS;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  typedef logic [ADDR_WIDTH-1:ADDR_OFS] addr_t;

  // Action selected for the next PC, in fixed priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_SEQ,
    ACT_TRAP,
    ACT_BRANCH,
    ACT_RET,
    ACT_CALL,
    ACT_CALL_RET
  } act_e;

  act_e           act;

  addr_t          pc_q, pc_d;
  logic           valid_q, valid_d;
  logic [PW-1:0]  ptr_q, ptr_d;   // next free slot; top entry is ptr_q-1
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  addr_t          ras_mem [RAS_DEPTH];
  logic           wr_en;
  logic [PW-1:0]  wr_idx;
  logic [PW-1:0]  top_idx;
  logic           ras_empty;
  logic           ras_full;

  assign top_idx   = ptr_q - PTR_ONE;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  always_comb begin
    act = ACT_HOLD;
    if (trap)                   act = ACT_TRAP;
    else if (br_taken)          act = ACT_BRANCH;
    else if (ret && call)       act = ACT_CALL_RET;
    else if (ret)               act = ACT_RET;
    else if (call)              act = ACT_CALL;
    else if (valid_q && pc_ready) act = ACT_SEQ;
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;

    unique case (act)
      ACT_SEQ:    pc_d = pc_q + AW'(1);
      ACT_TRAP:   pc_d = trap_vec;
      ACT_BRANCH: pc_d = br_target;
      ACT_RET: begin
        if (ras_empty) begin
          pc_d  = ret_fallback;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_mem[top_idx];
          ptr_d = top_idx;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACT_CALL: begin
        // The pointer wraps, so a push on a full stack lands on the oldest slot.
        pc_d  = call_target;
        wr_en = 1'b1;
        ptr_d = ptr_q + PTR_ONE;
        if (ras_full) ovf_d = 1'b1;
        else          cnt_d = cnt_q + CNT_ONE;
      end
      ACT_CALL_RET: begin
        // Pop and push fused: the top is replaced in place; an empty
        // stack degenerates to a plain push.
        wr_en = 1'b1;
        if (ras_empty) begin
          pc_d  = ret_fallback;
          unf_d = 1'b1;
          ptr_d = ptr_q + PTR_ONE;
          cnt_d = CNT_ONE;
        end else begin
          pc_d   = ras_mem[top_idx];
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= rst_addr;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; entries beyond cnt_q are never read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) ras_mem[wr_idx] <= call_link;
  end

  assign pc_valid  = valid_q;
  assign pc_addr   = pc_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] rst_addr, trap_vec, br_target, call_target, call_link, ret_fallback;
  logic        trap, br_taken, call, ret, pc_ready;
  logic        pc_valid;
  logic [29:0] pc_addr;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .ADDR_WIDTH (32),
    .INSN_SIZE  (4),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_addr     (rst_addr),
    .trap         (trap),
    .trap_vec     (trap_vec),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .call         (call),
    .call_target  (call_target),
    .call_link    (call_link),
    .ret          (ret),
    .ret_fallback (ret_fallback),
    .pc_ready     (pc_ready),
    .pc_valid     (pc_valid),
    .pc_addr      (pc_addr),
    .ras_count    (ras_count),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, newest entry at the back.
  logic [29:0] m_pc;
  logic        m_valid, m_ovf, m_unf;
  logic [29:0] m_q[$];
  logic [29:0] m_tmp;
  bit          m_adv;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_pc    = rst_addr;
      m_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      chk_en  = 1;
    end else begin
      m_adv   = m_valid && pc_ready;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
      if (trap)          m_pc = trap_vec;
      else if (br_taken) m_pc = br_target;
      else if (ret && call) begin
        if (m_q.size() == 0) begin
          m_pc  = ret_fallback;
          m_unf = 1'b1;
          m_q.push_back(call_link);
        end else begin
          m_pc   = m_q[$];
          m_q[$] = call_link;
        end
      end else if (ret) begin
        if (m_q.size() == 0) begin
          m_pc  = ret_fallback;
          m_unf = 1'b1;
        end else begin
          m_tmp = m_q.pop_back();
          m_pc  = m_tmp;
        end
      end else if (call) begin
        m_pc = call_target;
        if (m_q.size() == DEPTH) begin
          m_tmp = m_q.pop_front();
          m_ovf = 1'b1;
        end
        m_q.push_back(call_link);
      end else if (m_adv) begin
        m_pc = m_pc + 30'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", 32'(pc_valid),  32'(m_valid));
      chk("cyc_pc",    32'(pc_addr),   32'(m_pc));
      chk("cyc_count", 32'(ras_count), 32'(m_q.size()));
      chk("cyc_ovf",   32'(ras_ovf),   32'(m_ovf));
      chk("cyc_unf",   32'(ras_unf),   32'(m_unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_addr = 30'h100;
    trap = 0; br_taken = 0; call = 0; ret = 0; pc_ready = 1;
    trap_vec = '0; br_target = '0; call_target = '0; call_link = '0; ret_fallback = '0;

    // Reset and sequential fetch
    repeat (3) tick();
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_pc",    32'(pc_addr),  32'h100);
    chk("rst_cnt",   32'(ras_count), 32'd0);
    rst = 1'b0;
    tick(); chk("seq0_valid", 32'(pc_valid), 32'd1); chk("seq0", 32'(pc_addr), 32'h100);
    tick(); chk("seq1", 32'(pc_addr), 32'h101);
    tick(); chk("seq2", 32'(pc_addr), 32'h102);

    // Stall and trap-over-branch priority
    br_taken = 1; br_target = 30'h200;
    tick(); br_taken = 0; pc_ready = 0;
    chk("br_200", 32'(pc_addr), 32'h200);
    tick(); tick();
    chk("hold_200", 32'(pc_addr), 32'h200);
    trap = 1; trap_vec = 30'h40; br_taken = 1; br_target = 30'h300;
    tick(); trap = 0; br_taken = 0; pc_ready = 1;
    chk("trap_40", 32'(pc_addr), 32'h40);
    chk("trap_cnt", 32'(ras_count), 32'd0);

    // Call / return, with a branch overriding call+ret in between
    call = 1; call_target = 30'h500; call_link = 30'h201;
    tick(); chk("call1", 32'(pc_addr), 32'h500); chk("call1_cnt", 32'(ras_count), 32'd1);
    call_target = 30'h600; call_link = 30'h501;
    tick(); chk("call2", 32'(pc_addr), 32'h600); chk("call2_cnt", 32'(ras_count), 32'd2);
    br_taken = 1; br_target = 30'h250; ret = 1;
    tick(); br_taken = 0; call = 0;
    chk("br_over_ras", 32'(pc_addr), 32'h250); chk("br_over_cnt", 32'(ras_count), 32'd2);
    ret_fallback = 30'h999;
    tick(); chk("ret1", 32'(pc_addr), 32'h501); chk("ret1_cnt", 32'(ras_count), 32'd1);
    tick(); chk("ret2", 32'(pc_addr), 32'h201); chk("ret2_cnt", 32'(ras_count), 32'd0);
    ret = 0;

    // Overflow then underflow
    call = 1;
    for (int i = 1; i <= 5; i++) begin
      call_target = 30'(32'h700 + i); call_link = 30'(i);
      tick();
      chk("ovf_call_pc",  32'(pc_addr),   32'h700 + 32'(i));
      chk("ovf_call_cnt", 32'(ras_count), (i > 4) ? 32'd4 : 32'(i));
      chk("ovf_pulse",    32'(ras_ovf),   (i == 5) ? 32'd1 : 32'd0);
    end
    call = 0; ret = 1; ret_fallback = 30'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("unf_ret_pc",  32'(pc_addr),   32'(5 - i));
      chk("unf_ret_cnt", 32'(ras_count), 32'(3 - i));
      chk("ovf_clear",   32'(ras_ovf),   32'd0);
    end
    tick();
    chk("unf_pc", 32'(pc_addr), 32'h77); chk("unf_pulse", 32'(ras_unf), 32'd1);
    chk("unf_cnt", 32'(ras_count), 32'd0);
    ret = 0;
    tick(); chk("unf_clear", 32'(ras_unf), 32'd0); chk("after_unf", 32'(pc_addr), 32'h78);

    // Address wrap, then call+ret on a non-empty and an empty stack
    br_taken = 1; br_target = 30'h3FFFFFFF;
    tick(); br_taken = 0; chk("wrap_pre", 32'(pc_addr), 32'h3FFFFFFF);
    tick(); chk("wrap_0", 32'(pc_addr), 32'h0);
    call = 1; call_target = 30'h99; call_link = 30'h10;
    tick();
    call_target = 30'h20; call_link = 30'h30; ret = 1;
    tick(); chk("cr_pc", 32'(pc_addr), 32'h10); chk("cr_cnt", 32'(ras_count), 32'd1);
    call = 0;
    tick(); chk("cr_top", 32'(pc_addr), 32'h30); chk("cr_top_cnt", 32'(ras_count), 32'd0);
    call = 1; call_link = 30'h66; ret_fallback = 30'h55;
    tick(); chk("cr_empty_pc", 32'(pc_addr), 32'h55); chk("cr_empty_unf", 32'(ras_unf), 32'd1);
    chk("cr_empty_cnt", 32'(ras_count), 32'd1);
    call = 0;
    tick(); chk("cr_empty_pop", 32'(pc_addr), 32'h66);
    ret = 0;

    // Reset in the middle of a stall with a partly filled stack
    call = 1; call_target = 30'h800; call_link = 30'hA;
    tick(); tick();
    call = 0; pc_ready = 0;
    tick(); chk("mid_cnt", 32'(ras_count), 32'd2); chk("mid_hold", 32'(pc_addr), 32'h800);
    rst = 1; rst_addr = 30'h123; trap = 1; trap_vec = 30'h40;
    tick(); chk("mid_rst_valid", 32'(pc_valid), 32'd0); chk("mid_rst_pc", 32'(pc_addr), 32'h123);
    chk("mid_rst_cnt", 32'(ras_count), 32'd0);
    rst_addr = 30'h124;
    tick(); chk("mid_rst_resample", 32'(pc_addr), 32'h124);
    rst = 0; trap = 0;
    tick(); chk("mid_rel_valid", 32'(pc_valid), 32'd1); chk("mid_rel_pc", 32'(pc_addr), 32'h124);
    tick(); chk("mid_rel_hold", 32'(pc_addr), 32'h124);
    pc_ready = 1;
    tick(); chk("mid_rel_seq", 32'(pc_addr), 32'h125);
    ret = 1; ret_fallback = 30'h31;
    tick(); chk("mid_rel_ret", 32'(pc_addr), 32'h31); chk("mid_rel_unf", 32'(ras_unf), 32'd1);
    ret = 0;
    tick(); chk("final_seq", 32'(pc_addr), 32'h32);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter INSN_SIZE, default 4, instruction size in bytes (power of two, 1..16).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-004 SHALL derive localparam ADDR_OFS = log2(INSN_SIZE); every address port below is word-granular, [ADDR_WIDTH-1:ADDR_OFS] ("AW").
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rst_addr  in  AW  reset vector.
REQ-008 trap  in  1  trap request.
REQ-009 trap_vec  in  AW  trap target.
REQ-010 br_taken  in  1  taken branch/jump.
REQ-011 br_target  in  AW  branch target.
REQ-012 call  in  1  call redirect; call_target  in  AW; call_link  in  AW return address to push.
REQ-013 ret  in  1  return redirect; ret_fallback  in  AW  target used when the stack is empty.
REQ-014 pc_ready  in  1  fetch accepts pc_addr this cycle.
REQ-015 pc_valid  out  1  pc_addr is valid for fetch.
REQ-016 pc_addr  out  AW  current fetch address.
REQ-017 ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
REQ-018 ras_ovf  out  1  one-cycle pulse: push onto a full stack; ras_unf  out  1  one-cycle pulse: ret on an empty stack.

Function
REQ-019 SHALL select the next PC by fixed priority: rst > trap > br_taken > ret > call > sequential > hold.
REQ-020 trap: pc_addr <= trap_vec next cycle; stack untouched; pc_valid=1.
REQ-021 br_taken: pc_addr <= br_target next cycle; lower-priority ret/call in the same cycle ignored, stack untouched.
REQ-022 ret only: non-empty -> pc_addr <= top entry, count-1; empty -> pc_addr <= ret_fallback, count stays 0, ras_unf=1 for one cycle.
REQ-023 call only: pc_addr <= call_target; push call_link; count+1.
REQ-024 call on full stack: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_ovf=1 for one cycle.
REQ-025 call and ret together (no higher event): pc_addr <= top entry (ret_fallback if empty, ras_unf=1); top replaced by call_link (pushed if empty); count unchanged, except 0 -> 1.
REQ-026 Sequential: pc_valid && pc_ready with no redirect -> pc_addr <= pc_addr+1, modulo 2^(ADDR_WIDTH-ADDR_OFS) (all-ones wraps to 0, no flag).
REQ-027 Hold: pc_valid && !pc_ready with no redirect -> pc_addr and pc_valid unchanged.
REQ-028 Redirects SHALL apply regardless of pc_ready; the redirected address is presented with pc_valid=1 on the following cycle, latency 1.
REQ-029 pc_addr SHALL be a register output; no combinational path from any input to pc_addr or pc_valid.
REQ-030 ras_ovf/ras_unf SHALL be registered and asserted in the cycle the new pc_addr appears.

Reset
REQ-031 While rst=1: pc_valid=0, pc_addr=rst_addr (sampled each cycle), ras_count=0, ras_ovf=0, ras_unf=0; all other inputs ignored.
REQ-032 First cycle after rst falls: pc_valid=1, pc_addr=last sampled rst_addr.
REQ-033 rst mid-operation (pending hold, partly filled stack) SHALL discard all state within one cycle; stack contents are don't-care, count=0.

Verification
REQ-034 Reset/sequence (ADDR_WIDTH=32, INSN_SIZE=4): rst_addr=0x100 word, rst 3 cycles, pc_ready=1 -> pc_valid=1 with 0x100, 0x101, 0x102 on consecutive cycles.
REQ-035 Stall/priority: pc_ready=0 for 2 cycles at 0x200 -> 0x200 held; same-cycle trap (vec 0x40) + br_taken (0x300) -> 0x40 next cycle, count unchanged.
REQ-036 Call/return: call target 0x500 link 0x201, then call target 0x600 link 0x501, then ret, ret -> 0x500, 0x600, 0x501, 0x201; ras_count 1, 2, 1, 0.
REQ-037 Overflow/underflow (RAS_DEPTH=4): 5 calls with links 1..5 -> ras_ovf pulse on 5th, count=4; 4 rets -> 5, 4, 3, 2; 5th ret with ret_fallback=0x77 -> 0x77, ras_unf pulse, count 0.
REQ-038 Wrap and call+ret: pc_addr=0x3FFFFFFF, ready -> 0x0; stack top 0x10, call+ret with target 0x20, link 0x30 -> pc 0x10, top now 0x30, count unchanged.
